// File: rtl/fifo_rd_packer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_rd_packer_if
// Brief    : Bundles the FIFO read-side, flush and packed-output handshake
//            signals of fifo_rd_packer.
//            master = the packer, slave = its FIFO/downstream environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if #(
  parameter int WIDTH = 4,
  parameter int PACK  = 4
);
  // FIFO read side
  logic                    fifo_empty;
  logic [WIDTH-1:0]        fifo_data;
  logic                    fifo_rd_en;
  // flush request / completion
  logic                    flush;
  logic                    flush_done;
  // packed output word
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH*PACK-1:0]   out_data;
  logic [PACK-1:0]         out_keep;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flush,
    input  out_ready,
    output fifo_rd_en,
    output flush_done,
    output out_valid,
    output out_data,
    output out_keep
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flush,
    output out_ready,
    input  fifo_rd_en,
    input  flush_done,
    input  out_valid,
    input  out_data,
    input  out_keep
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_rd_packer
// Brief    : Read-side consumer of an async FIFO (rd_clk domain). Pops
//            WIDTH-bit entries and packs PACK of them into one output word
//            with a valid/ready handshake. A flush emits the partial word
//            with a lane-keep mask and pulses flush_done.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int WIDTH = 4,
  parameter int PACK  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,   // synchronous, active-low
  fifo_rd_packer_if.master      bus
);

  localparam int CNT_W = $clog2(PACK + 1);

  localparam logic [1:0] c_fill  = 2'd0;   // normal packing
  localparam logic [1:0] c_fwait = 2'd1;   // flush: wait for in-flight entry
  localparam logic [1:0] c_femit = 2'd2;   // flush: emit partial / finish

  localparam logic [CNT_W-1:0] c_full = CNT_W'(PACK);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [WIDTH*PACK-1:0] r_acc;
  logic [WIDTH*PACK-1:0] w_acc_capt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_inflight;
  logic [CNT_W:0]        w_occupied;
  logic [PACK-1:0]       w_part_keep;
  logic                  w_out_free;
  logic                  w_fill;
  logic                  w_pop;
  logic                  w_transfer;
  logic                  w_flush_emit;
  logic                  w_flush_done;

  // The output register can take a new word when empty or being accepted now.
  assign w_out_free = !bus.out_valid || bus.out_ready;

  // Lanes already filled plus the one whose data is still on its way.
  assign w_occupied = {1'b0, r_cnt} + (CNT_W + 1)'(r_inflight);

  // Only pop while filling and a free lane remains for the popped entry;
  // rd_rst is active-low, so the pop is suppressed while reset is held.
  assign w_pop = rd_rst && !bus.fifo_empty && w_fill &&
                 (w_occupied < (CNT_W + 1)'(PACK));

  assign bus.fifo_rd_en = w_pop;

  // A full accumulator moves to the output register in any state.
  assign w_transfer = (r_cnt == c_full) && w_out_free;

  // State register for the flush controller.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      r_state <= c_fill;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: flush drains the in-flight entry, then emits.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_fill: begin
        if (bus.flush) begin
          w_state_next = c_fwait;
        end
      end
      c_fwait: begin
        if (!r_inflight) begin
          w_state_next = c_femit;
        end
      end
      c_femit: begin
        // A full accumulator is left to the normal transfer; once cnt
        // returns to zero the flush completes without a partial word.
        if (w_flush_done) begin
          w_state_next = c_fill;
        end
      end
      default: begin
        w_state_next = c_fill;
      end
    endcase
  end

  // FSM outputs: pop enable, partial-word emit and flush completion.
  always_comb begin
    w_fill       = (r_state == c_fill);
    w_flush_emit = 1'b0;
    w_flush_done = 1'b0;
    if (r_state == c_femit) begin
      if (r_cnt == '0) begin
        w_flush_done = 1'b1;
      end else if ((r_cnt != c_full) && w_out_free) begin
        w_flush_emit = 1'b1;
        w_flush_done = 1'b1;
      end
    end
  end

  // Lane write for the arriving FIFO entry and keep mask for a partial word.
  always_comb begin
    w_acc_capt  = r_acc;
    w_part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (r_inflight && (r_cnt == CNT_W'(i))) begin
        w_acc_capt[i*WIDTH +: WIDTH] = bus.fifo_data;
      end
      w_part_keep[i] = (CNT_W'(i) < r_cnt);
    end
  end

  // Accumulator, fill count and in-flight tracking. A capture and a
  // transfer never coincide because pops stop once all lanes are claimed.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      if (w_transfer || w_flush_emit) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_inflight) begin
        r_acc <= w_acc_capt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output register: load full or partial words, hold while stalled,
  // clear valid on acceptance when nothing new is loaded.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_keep   <= '0;
      bus.flush_done <= 1'b0;
    end else begin
      bus.flush_done <= w_flush_done;
      if (w_transfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= r_acc;
        bus.out_keep  <= '1;
      end else if (w_flush_emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= r_acc;
        bus.out_keep  <= w_part_keep;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
